mult_sequencer: RTL and testbench

Counter-based control unit for the 8-bit signed add-shift multiplier datapath: the X/A/B shift registers and the 9-bit adder/subtractor. It accepts a Load request and a Run button and sequences clear, add-or-subtract, and shift micro-operations for N bit-iterations. It then holds a Done indication until Run is released. It sits between the synchronized switch/button inputs and the register/adder datapath, replacing any unrolled per-bit state list with a loop counter.

---
 rtl/mult_pkg.sv | 16 +
 rtl/rise_detect.sv | 20 ++
 rtl/mult_sequencer.sv | 97 +++++++++
 tb/tb_mult_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the add-shift
// multiplier control unit.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

  localparam int MULT_N = 8;
  localparam int CNT_W  = $clog2(MULT_N);

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already
// synchronized level; stored bit resets high.
module rise_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Rise
);

  logic q;

  // Previous level; reset high so a held input is not an edge
  always_ff @(posedge Clk) begin
    if (Reset) q <= 1'b1;
    else       q <= In;
  end

  assign Rise = In & ~q;

endmodule

// File: rtl/mult_sequencer.sv
// Loop-counter control unit sequencing clear,
// add/sub and shift for the signed multiplier.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic               Run,
  input  logic               M,
  output logic               Clr_XA,
  output logic               Ld_B,
  output logic               Add,
  output logic               Sub,
  output logic               Shift,
  output logic               Busy,
  output logic               Done,
  output logic [$clog2(N)-1:0] Count
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mult_state_t   state;
  mult_state_t   next;
  logic [CW-1:0] count_next;
  logic          run_rise;

  rise_detect u_rise (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (Run),
    .Rise  (run_rise)
  );

  // State and iteration counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Count <= '0;
    end else begin
      state <= next;
      Count <= count_next;
    end
  end

  // Next state and micro-operation strobes
  always_comb begin
    next       = state;
    count_next = Count;
    Clr_XA     = 1'b0;
    Ld_B       = 1'b0;
    Add        = 1'b0;
    Sub        = 1'b0;
    Shift      = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      IDLE: begin
        Ld_B = Load;
        if (run_rise && !Load) next = CLEAR;
      end
      CLEAR: begin
        Clr_XA     = 1'b1;
        Busy       = 1'b1;
        count_next = '0;
        next       = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        if (M) begin
          if (Count == LAST) Sub = 1'b1;
          else               Add = 1'b1;
        end
        next = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (Count == LAST) begin
          next = DONE;
        end else begin
          count_next = Count + 1'b1;
          next       = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized bench for mult_sequencer with a
// timeline model and an 8-bit datapath model.
module tb_mult_sequencer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic       run = 1'b1;
  logic       m;
  logic       clr_xa, ld_b, add, sub;
  logic       shift, busy, done;
  logic [2:0] count;

  always #5 clk = ~clk;

  mult_sequencer #(.N(N)) dut (
    .Clk    (clk),
    .Reset  (reset),
    .Load   (load),
    .Run    (run),
    .M      (m),
    .Clr_XA (clr_xa),
    .Ld_B   (ld_b),
    .Add    (add),
    .Sub    (sub),
    .Shift  (shift),
    .Busy   (busy),
    .Done   (done),
    .Count  (count)
  );

  typedef struct packed {
    logic       clr;
    logic       ldb;
    logic       add;
    logic       sub;
    logic       shift;
    logic       busy;
    logic       done;
    logic [2:0] cnt;
  } exp_t;

  // model: 0 idle, 1 running (m_o cycles since rise), 2 done
  int   m_mode = 0;
  int   m_o = 0;
  int   m_age = 0;
  int   m_cnt = 0;
  logic m_rq = 1'b1;

  logic       x_r = 1'b0;
  logic [7:0] a_r = '0;
  logic [7:0] b_r = '0;
  logic [7:0] b0 = '0;
  logic [7:0] s_r = '0;
  logic [7:0] sw = '0;
  int cyc = 0;

  exp_t ex;
  int   k;

  assign m = b_r[0];

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    ex = '0;
    k = 0;
    ex.cnt = 3'(m_cnt);
    case (m_mode)
      0: ex.ldb = load;
      1: begin
        ex.busy = 1'b1;
        if (m_o == 1) begin
          ex.clr = 1'b1;
        end else begin
          k = (m_o - 2) / 2;
          ex.cnt = 3'(k);
          if (m_o % 2 == 0) begin
            ex.add = b_r[0] && (k < N - 1);
            ex.sub = b_r[0] && (k == N - 1);
          end else begin
            ex.shift = 1'b1;
          end
        end
      end
      default: begin
        ex.done = 1'b1;
        ex.cnt = 3'(N - 1);
      end
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0;
      m_rq <= 1'b1;
      m_cnt <= 0;
    end else begin
      m_rq <= run;
      if (ex.ldb) b_r <= sw;
      if (ex.clr) begin
        x_r <= 1'b0;
        a_r <= '0;
        b0 <= b_r;
        m_cnt <= 0;
      end
      if (ex.add) {x_r, a_r} <= {a_r[7], a_r} + {s_r[7], s_r};
      if (ex.sub) {x_r, a_r} <= {a_r[7], a_r} - {s_r[7], s_r};
      if (ex.shift) begin
        a_r <= {x_r, a_r[7:1]};
        b_r <= {a_r[0], b_r[7:1]};
      end
      case (m_mode)
        0: if (!load && run && !m_rq) begin
          m_mode <= 1;
          m_o <= 1;
        end
        1: if (m_o == 2 * N + 1) begin
          m_mode <= 2;
          m_age <= 0;
          m_cnt <= N - 1;
        end else begin
          m_o <= m_o + 1;
        end
        default: begin
          m_age <= m_age + 1;
          if (!run) m_mode <= 0;
        end
      endcase
    end
  end

  int checks = 0;
  int errors = 0;
  int n_ld = 0, n_busy = 0, n_clr = 0;
  int n_add = 0, n_sub = 0, n_prod = 0;
  int last_clr = -1, first_done = -1;
  int t_ref = 0;
  logic [31:0] addmask, submask, shmask;
  logic prev_done = 1'b0;

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic observe();
    int rel;
    logic [9:0] act;
    logic signed [15:0] p_exp;
    act = {clr_xa, ld_b, add, sub, shift, busy, done, count};
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL outputs cyc=%0d: got %b expected %b",
               cyc, act, ex);
    end
    if (m_mode == 2 && m_age == 0) begin
      p_exp = $signed(s_r) * $signed(b0);
      n_prod++;
      checks++;
      if ({a_r, b_r} !== p_exp) begin
        errors++;
        $display("FAIL product: got %0h expected %0h",
                 {a_r, b_r}, p_exp);
      end
    end
    rel = cyc - t_ref;
    if (ld_b) n_ld++;
    if (busy) n_busy++;
    if (clr_xa) begin
      n_clr++;
      last_clr = cyc;
    end
    if (add) n_add++;
    if (sub) n_sub++;
    if (rel >= 0 && rel < 32) begin
      if (add) addmask[rel] = 1'b1;
      if (sub) submask[rel] = 1'b1;
      if (shift) shmask[rel] = 1'b1;
    end
    if (done && !prev_done) first_done = cyc;
    prev_done = done;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(string name);
    int g;
    g = 0;
    while (!done && g < 40) begin
      step(1);
      g++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
    step(1);
  endtask

  task automatic start_run();
    run = 1'b1;
    t_ref = cyc;
    addmask = '0;
    submask = '0;
    shmask = '0;
  endtask

  task automatic load_b(logic [7:0] bv, logic [7:0] sv);
    run = 1'b0;
    load = 1'b1;
    sw = bv;
    s_r = sv;
    step(1);
    load = 1'b0;
    step(1);
  endtask

  initial begin
    int base_a, base_b, base_c, t;
    reset = 1'b1;
    run = 1'b1;
    step(3);
    reset = 1'b0;
    fork
      forever begin
        @(negedge clk);
        observe();
      end
    join_none
    chk("reset_outputs",
        int'({clr_xa, ld_b, add, sub, shift, busy, done, count}), 0);
    base_c = n_clr;
    step(4);
    chk("held_run_no_start", n_clr - base_c, 0);

    run = 1'b0;
    step(1);
    base_a = n_ld;
    base_b = n_busy;
    load = 1'b1;
    sw = 8'h07;
    step(3);
    load = 1'b0;
    step(2);
    chk("load_pulses", n_ld - base_a, 3);
    chk("load_no_busy", n_busy - base_b, 0);

    load_b(8'h07, 8'd9);
    base_a = n_add;
    base_b = n_sub;
    start_run();
    t = t_ref;
    wait_done("b07");
    chk("b07_clr_cycle", last_clr - t, 1);
    chk("b07_add_count", n_add - base_a, 3);
    chk("b07_add_mask", int'(addmask), 32'h54);
    chk("b07_sub_count", n_sub - base_b, 0);
    chk("b07_shift_mask", int'(shmask), 32'h2AAA8);
    chk("b07_done_cycle", first_done - t, 18);
    chk("b07_product", int'({a_r, b_r}), 16'h003F);

    step(10);
    chk("done_held", int'(done), 1);
    run = 1'b0;
    step(1);
    step(1);
    chk("idle_after_fall", int'({busy, done}), 0);
    start_run();
    t = t_ref;
    step(2);
    chk("reclear_cycle", last_clr - t, 1);
    wait_done("rerun");
    run = 1'b0;
    step(2);

    load_b(8'h80, 8'd5);
    base_a = n_add;
    base_b = n_sub;
    start_run();
    t = t_ref;
    wait_done("b80");
    chk("b80_add_count", n_add - base_a, 0);
    chk("b80_sub_count", n_sub - base_b, 1);
    chk("b80_sub_mask", int'(submask), 32'h10000);
    chk("b80_done_cycle", first_done - t, 18);
    chk("b80_product", int'({a_r, b_r}), 16'hFD80);
    run = 1'b0;
    step(2);

    load_b(8'hFF, 8'd3);
    start_run();
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midreset_outputs",
        int'({clr_xa, ld_b, add, sub, shift, busy, done, count}), 0);
    base_c = n_clr;
    step(5);
    chk("midreset_no_restart", n_clr - base_c, 0);
    run = 1'b0;
    step(1);
    start_run();
    t = t_ref;
    step(2);
    chk("midreset_restart", last_clr - t, 1);
    wait_done("restart");
    run = 1'b0;
    step(2);

    base_a = n_ld;
    base_b = n_busy;
    base_c = n_clr;
    load = 1'b1;
    sw = 8'h33;
    run = 1'b1;
    step(1);
    load = 1'b0;
    step(5);
    chk("loadrun_ldb", n_ld - base_a, 1);
    chk("loadrun_no_clr", n_clr - base_c, 0);
    chk("loadrun_no_busy", n_busy - base_b, 0);
    run = 1'b0;
    step(2);

    base_a = n_prod;
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 9) == 0);
      sw = 8'($urandom);
      if (m_mode == 0 && $urandom_range(0, 3) == 0)
        s_r = 8'($urandom);
      if ($urandom_range(0, 5) == 0) run = ~run;
      step(1);
    end
    chk("random_runs_seen", int'(n_prod - base_a > 5), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
